// File: rtl/tlm_pkg.sv
// Shared types and constants for the telemetry frame sequencer.
// State encoding, frame geometry and payload index helpers.
package tlm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    GUARD,
    WAIT,
    DONE
  } state_t;

  localparam int          FRAME_LEN = 9;
  localparam logic [3:0]  LAST_IDX  = 4'd8;
  localparam logic [3:0]  PAY_FIRST = 4'd2;
  localparam logic [3:0]  PAY_LAST  = 4'd7;

  function automatic logic is_payload(input logic [3:0] idx);
    return (idx >= PAY_FIRST) && (idx <= PAY_LAST);
  endfunction

endpackage

// File: rtl/tlm_chk_acc.sv
// 8-bit wrapping byte-sum accumulator for the frame checksum.
// Output is the inverted sum, so payload + checksum == 8'hFF.
module tlm_chk_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_add,
  input  logic [7:0] i_data,
  output logic [7:0] o_chk
);

  logic [7:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= 8'h00;
    end else if (i_clr) begin
      r_sum <= 8'h00;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_chk = ~r_sum;

endmodule

// File: rtl/tlm_frame_tx.sv
// Telemetry frame sequencer feeding a byte UART transmitter.
// Snapshots ptch/lft_spd/rght_spd and streams a 9-byte frame.
import tlm_pkg::*;

module tlm_frame_tx #(
  parameter logic [7:0] HDR0 = 8'hAA,
  parameter logic [7:0] HDR1 = 8'h55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd,
  input  logic [15:0] ptch,
  input  logic [15:0] lft_spd,
  input  logic [15:0] rght_spd,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        frm_done
);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [15:0] r_ptch;
  logic [15:0] r_lft;
  logic [15:0] r_rght;
  logic        r_trmt;
  logic [7:0]  r_tx_data;
  logic        r_busy;
  logic        r_frm_done;

  logic [7:0]  w_byte;
  logic [7:0]  w_chk;
  logic        w_clr;
  logic        w_add;

  assign w_clr = (r_state == IDLE) && snd;
  // Sum the byte that is on tx_data during its trmt cycle.
  assign w_add = (r_state == PULSE) && is_payload(r_idx);

  tlm_chk_acc u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_add  (w_add),
    .i_data (r_tx_data),
    .o_chk  (w_chk)
  );

  always_comb begin
    w_byte = 8'h00;
    unique case (r_idx)
      4'd0:    w_byte = HDR0;
      4'd1:    w_byte = HDR1;
      4'd2:    w_byte = r_ptch[15:8];
      4'd3:    w_byte = r_ptch[7:0];
      4'd4:    w_byte = r_lft[15:8];
      4'd5:    w_byte = r_lft[7:0];
      4'd6:    w_byte = r_rght[15:8];
      4'd7:    w_byte = r_rght[7:0];
      4'd8:    w_byte = w_chk;
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= 4'd0;
      r_ptch     <= 16'h0000;
      r_lft      <= 16'h0000;
      r_rght     <= 16'h0000;
      r_trmt     <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
      r_frm_done <= 1'b0;
    end else begin
      r_trmt     <= 1'b0;
      r_frm_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (snd) begin
            r_ptch  <= ptch;
            r_lft   <= lft_spd;
            r_rght  <= rght_spd;
            r_idx   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_tx_data <= w_byte;
          r_trmt    <= 1'b1;
          r_state   <= PULSE;
        end
        PULSE: r_state <= GUARD;
        // tx_done may still be high from the previous byte here.
        GUARD: r_state <= WAIT;
        WAIT: begin
          if (tx_done) begin
            if (r_idx == LAST_IDX) begin
              r_frm_done <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= LOAD;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign trmt     = r_trmt;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign frm_done = r_frm_done;

endmodule
